mem_rr_arbiter: RTL and testbench



---
 rtl/mem_rr_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_mem_rr_arbiter.sv | 483 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one narrow memory request/response port between NumPorts requesters.
//
// Requests are arbitrated round-robin and forwarded with zero added latency. Every accepted read
// pushes the requester index into an in-order ID FIFO. Each downstream read response is routed to
// the port at the FIFO head, so any fixed or variable downstream latency works. Writes produce no
// response and never take a FIFO slot.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   req_valid_i/ready_o     per-port request handshake
//   req_addr_i/write_i      per-port address and write flag (1 = write)
//   req_wdata_i/strb_i      per-port write data and byte strobes
//   rsp_valid_o             one-hot read-data valid, routed to the issuing port
//   rsp_data_o              read data, broadcast to all ports
//   rsp_ready_i             per-port read-data ready
//   mem_req_*               downstream request (muxed from the granted port)
//   mem_rsp_*               downstream read response
//   outstanding_o           number of reads in flight
//   stall_cnt_o             per-port 32-bit saturating stall counters
//                           (only with LAGD_MEM_ARB_STALL_CNT_EN defined)
//
// Optional feature macro: LAGD_MEM_ARB_STALL_CNT_EN

module mem_rr_arbiter #(
  parameter int unsigned NumPorts       = 4,
  parameter int unsigned AddrWidth      = 48,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned IdxW  = (NumPorts > 1) ? $clog2(NumPorts) : 1,
  localparam int unsigned StrbW = DataWidth / 8,
  localparam int unsigned CntW  = $clog2(MaxOutstanding + 1),
  localparam int unsigned PtrW  = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumPorts-1:0]           req_valid_i,
  output logic [NumPorts-1:0]           req_ready_o,
  input  logic [NumPorts*AddrWidth-1:0] req_addr_i,
  input  logic [NumPorts-1:0]           req_write_i,
  input  logic [NumPorts*DataWidth-1:0] req_wdata_i,
  input  logic [NumPorts*StrbW-1:0]     req_strb_i,
  output logic [NumPorts-1:0]           rsp_valid_o,
  output logic [DataWidth-1:0]          rsp_data_o,
  input  logic [NumPorts-1:0]           rsp_ready_i,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [AddrWidth-1:0]          mem_addr_o,
  output logic                          mem_write_o,
  output logic [DataWidth-1:0]          mem_wdata_o,
  output logic [StrbW-1:0]              mem_strb_o,
  input  logic                          mem_rsp_valid_i,
  input  logic [DataWidth-1:0]          mem_rsp_data_i,
  output logic                          mem_rsp_ready_o,
`ifdef LAGD_MEM_ARB_STALL_CNT_EN
  output logic [NumPorts*32-1:0]        stall_cnt_o,
`endif
  output logic [CntW-1:0]               outstanding_o
);

  logic [IdxW-1:0]     rr_q, rr_d;
  logic [IdxW-1:0]     grant;
  logic                any_elig;
  logic                handshake;
  logic [NumPorts-1:0] eligible;

  logic [IdxW-1:0] id_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_full, fifo_empty;
  logic            push, pop;
  logic [IdxW-1:0] head;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full  = (count_q == CntW'(MaxOutstanding));
  assign fifo_empty = (count_q == '0);

  // A full FIFO blocks reads only; full is the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign eligible = req_valid_i & (req_write_i | {NumPorts{~fifo_full}});

  // First eligible port at or after the round-robin pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    grant    = rr_q;
    any_elig = 1'b0;
    for (int unsigned k = 0; k < NumPorts; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NumPorts) idx = idx - NumPorts;
      if (!any_elig && eligible[IdxW'(idx)]) begin
        any_elig = 1'b1;
        grant    = IdxW'(idx);
      end
    end
  end

  assign mem_req_valid_o = any_elig;
  assign mem_addr_o      = req_addr_i[grant*AddrWidth +: AddrWidth];
  assign mem_write_o     = req_write_i[grant];
  assign mem_wdata_o     = req_wdata_i[grant*DataWidth +: DataWidth];
  assign mem_strb_o      = req_strb_i[grant*StrbW +: StrbW];

  assign handshake = any_elig && mem_req_ready_i;
  assign push      = handshake && !mem_write_o;

  always_comb begin
    req_ready_o        = '0;
    req_ready_o[grant] = handshake;
  end

  always_comb begin
    rr_d = rr_q;
    if (handshake) rr_d = (grant == IdxW'(NumPorts - 1)) ? '0 : grant + 1'b1;
  end

  // Response routing; with an empty FIFO any response is accepted and dropped.
  assign head       = id_q[rd_ptr_q];
  assign rsp_data_o = mem_rsp_data_i;

  always_comb begin
    rsp_valid_o     = '0;
    mem_rsp_ready_o = 1'b1;
    if (!fifo_empty) begin
      rsp_valid_o[head] = mem_rsp_valid_i;
      mem_rsp_ready_o   = rsp_ready_i[head];
    end
  end

  assign pop           = !fifo_empty && mem_rsp_valid_i && mem_rsp_ready_o;
  assign outstanding_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < MaxOutstanding; i++) id_q[i] <= '0;
    end else begin
      rr_q <= rr_d;
      if (push) begin
        id_q[wr_ptr_q] <= grant;
        wr_ptr_q       <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

`ifdef LAGD_MEM_ARB_STALL_CNT_EN
  logic [31:0] stall_cnt_q [NumPorts];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumPorts; i++) stall_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NumPorts; i++) begin
        if (req_valid_i[i] && !req_ready_o[i] && (stall_cnt_q[i] != 32'hFFFF_FFFF)) begin
          stall_cnt_q[i] <= stall_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int i = 0; i < NumPorts; i++) stall_cnt_o[i*32 +: 32] = stall_cnt_q[i];
  end
`endif

`ifndef SYNTHESIS
  rsp_onehot_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(rsp_valid_o)) else $error("rsp_valid_o has more than one bit set");
  req_ready_onehot_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o)) else $error("req_ready_o has more than one bit set");
  outstanding_max_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    outstanding_o <= CntW'(MaxOutstanding)) else $error("outstanding_o above MaxOutstanding");
  rsp_when_empty_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rsp_valid_i && fifo_empty)) else $error("read response with no read in flight");
`endif

endmodule

// File: tb/tb_mem_rr_arbiter.sv
module tb_mem_rr_arbiter;

  localparam int NP = 4;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [NP-1:0]     req_valid_i;
  logic [NP-1:0]     req_ready_o;
  logic [NP*AW-1:0]  req_addr_i;
  logic [NP-1:0]     req_write_i;
  logic [NP*DW-1:0]  req_wdata_i;
  logic [NP*SW-1:0]  req_strb_i;
  logic [NP-1:0]     rsp_valid_o;
  logic [DW-1:0]     rsp_data_o;
  logic [NP-1:0]     rsp_ready_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [AW-1:0]     mem_addr_o;
  logic              mem_write_o;
  logic [DW-1:0]     mem_wdata_o;
  logic [SW-1:0]     mem_strb_o;
  logic              mem_rsp_valid_i;
  logic [DW-1:0]     mem_rsp_data_i;
  logic              mem_rsp_ready_o;
  logic [2:0]        outstanding_o;
`ifdef LAGD_MEM_ARB_STALL_CNT_EN
  logic [NP*32-1:0]  stall_cnt_o;
`endif

  mem_rr_arbiter #(
    .NumPorts(NP), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(4)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr_i),
    .req_write_i    (req_write_i),
    .req_wdata_i    (req_wdata_i),
    .req_strb_i     (req_strb_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_data_o     (rsp_data_o),
    .rsp_ready_i    (rsp_ready_i),
    .mem_req_valid_o(mem_req_valid_o),
    .mem_req_ready_i(mem_req_ready_i),
    .mem_addr_o     (mem_addr_o),
    .mem_write_o    (mem_write_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_strb_o     (mem_strb_o),
    .mem_rsp_valid_i(mem_rsp_valid_i),
    .mem_rsp_data_i (mem_rsp_data_i),
    .mem_rsp_ready_o(mem_rsp_ready_o),
`ifdef LAGD_MEM_ARB_STALL_CNT_EN
    .stall_cnt_o    (stall_cnt_o),
`endif
    .outstanding_o  (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          port;
    logic [63:0] data;
  } exp_t;

  exp_t        exp_q[$];   // expected responses, in issue order
  logic [63:0] mem_q[$];   // data the memory model will return, in issue order
  int          checks = 0;
  int          errors = 0;

  // ---------------- stimulus helpers (no comparisons) ----------------
  function automatic logic [63:0] data_of(input logic [47:0] a);
    return {16'hC0DE, a};
  endfunction

  function automatic logic [63:0] wdata_of(input int p, input logic [47:0] a);
    return {8'(p), 8'hA5, a};
  endfunction

  function automatic logic [7:0] strb_of(input int p);
    return 8'(8'h11 << p);
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input int p, input bit v, input bit w, input logic [47:0] a);
    req_valid_i[p]            = v;
    req_write_i[p]            = w;
    req_addr_i[p*AW +: AW]    = a;
    req_wdata_i[p*DW +: DW]   = wdata_of(p, a);
    req_strb_i[p*SW +: SW]    = strb_of(p);
  endtask

  task automatic exp_push(input int p, input logic [63:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    exp_q.push_back(e);
    mem_q.push_back(d);
  endtask

  task automatic rsp_drive(input bit on);
    mem_rsp_valid_i = on;
    mem_rsp_data_i  = (on && mem_q.size() != 0) ? mem_q[0] : '0;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) begin
      rsp_drive(1'b1);
      @(negedge clk_i);
      tick();
      void'(mem_q.pop_front());
    end
    rsp_drive(1'b0);
  endtask

  task automatic apply_reset();
    req_valid_i     = '0;
    req_write_i     = '0;
    mem_rsp_valid_i = 1'b0;
    rst_ni          = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    exp_q.delete();
    mem_q.delete();
  endtask

  // ---------------- response scoreboard ----------------
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && (rsp_valid_o & rsp_ready_i) != '0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rsp_valid_o=%b data=%h, expected no response",
                 rsp_valid_o, rsp_data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (rsp_valid_o !== 4'(1 << e.port) || rsp_data_o !== e.data) begin
          errors++;
          $display("FAIL rsp_route: got valid=%b data=%h, expected valid=%b data=%h",
                   rsp_valid_o, rsp_data_o, 4'(1 << e.port), e.data);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    req_valid_i = '0; req_write_i = '0; req_addr_i = '0; req_wdata_i = '0; req_strb_i = '0;
    rsp_ready_i = '1; mem_req_ready_i = 1'b1; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o, outstanding_o} !==
        {4'b0, 4'b0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b rv=%b mv=%b mrr=%b out=%0d, expected 0 0 0 1 0",
               req_ready_o, rsp_valid_o, mem_req_valid_o, mem_rsp_ready_o, outstanding_o);
    end
    tick();
  endtask

  task automatic test_single_read();
    set_req(0, 1'b1, 1'b0, 48'h1000);
    exp_push(0, 64'hDEAD_BEEF);
    @(negedge clk_i);
    checks++;
    if (mem_req_valid_o !== 1'b1 || mem_addr_o !== 48'h1000 || mem_write_o !== 1'b0 ||
        req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL single_issue: got mv=%b addr=%h wr=%b rdy=%b, expected 1 1000 0 0001",
               mem_req_valid_o, mem_addr_o, mem_write_o, req_ready_o);
    end
    tick();
    set_req(0, 1'b0, 1'b0, 48'h0);
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd1) begin
      errors++;
      $display("FAIL single_outstanding1: got %0d, expected 1", outstanding_o);
    end
    tick();
    rsp_drive(1'b1);
    @(negedge clk_i);
    checks++;
    if (rsp_valid_o !== 4'b0001 || rsp_data_o !== 64'hDEAD_BEEF || outstanding_o !== 3'd1) begin
      errors++;
      $display("FAIL single_rsp: got rv=%b data=%h out=%0d, expected 0001 deadbeef 1",
               rsp_valid_o, rsp_data_o, outstanding_o);
    end
    tick();
    rsp_drive(1'b0);
    void'(mem_q.pop_front());
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd0 || rsp_valid_o !== 4'b0) begin
      errors++;
      $display("FAIL single_outstanding0: got out=%0d rv=%b, expected 0 0000",
               outstanding_o, rsp_valid_o);
    end
    tick();
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 1'b0, 48'(32'h100 * (p + 1)));
    for (int c = 0; c < NP; c++) begin
      exp_push(c, data_of(48'(32'h100 * (c + 1))));
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 4'(1 << c) || mem_addr_o !== 48'(32'h100 * (c + 1))) begin
        errors++;
        $display("FAIL fair_grant%0d: got rdy=%b addr=%h, expected %b %h", c, req_ready_o,
                 mem_addr_o, 4'(1 << c), 48'(32'h100 * (c + 1)));
      end
      tick();
      set_req(c, 1'b0, 1'b0, 48'h0);
    end
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd4) begin
      errors++;
      $display("FAIL fair_outstanding: got %0d, expected 4", outstanding_o);
    end
    tick();
    drain(4);
    // Pointer wrapped back to 0: port 0 wins over port 3.
    set_req(0, 1'b1, 1'b0, 48'h500);
    set_req(3, 1'b1, 1'b0, 48'h800);
    exp_push(0, data_of(48'h500));
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL fair_wrap: got rdy=%b, expected 0001", req_ready_o);
    end
    tick();
    set_req(0, 1'b0, 1'b0, 48'h0);
    exp_push(3, data_of(48'h800));
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 4'b1000) begin
      errors++;
      $display("FAIL fair_next: got rdy=%b, expected 1000", req_ready_o);
    end
    tick();
    set_req(3, 1'b0, 1'b0, 48'h0);
    drain(2);
  endtask

  task automatic test_full_stall();
    // Pointer is 0 here.
    for (int k = 0; k < 4; k++) begin
      set_req(1, 1'b1, 1'b0, 48'(32'h2000 + 8 * k));
      exp_push(1, data_of(48'(32'h2000 + 8 * k)));
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 4'b0010) begin
        errors++;
        $display("FAIL stall_fill%0d: got rdy=%b, expected 0010", k, req_ready_o);
      end
      tick();
    end
    set_req(1, 1'b1, 1'b0, 48'h2020);
    set_req(2, 1'b1, 1'b1, 48'h3000);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 4'b0100 || mem_write_o !== 1'b1 || mem_addr_o !== 48'h3000 ||
        outstanding_o !== 3'd4) begin
      errors++;
      $display("FAIL stall_write: got rdy=%b wr=%b addr=%h out=%0d, expected 0100 1 3000 4",
               req_ready_o, mem_write_o, mem_addr_o, outstanding_o);
    end
    tick();
    set_req(2, 1'b0, 1'b0, 48'h0);
    @(negedge clk_i);
    checks++;
    if (mem_req_valid_o !== 1'b0 || req_ready_o !== 4'b0) begin
      errors++;
      $display("FAIL stall_block: got mv=%b rdy=%b, expected 0 0000", mem_req_valid_o,
               req_ready_o);
    end
    tick();
    rsp_drive(1'b1);
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 4'b0 || outstanding_o !== 3'd4) begin
      errors++;
      $display("FAIL stall_no_bypass: got rdy=%b out=%0d, expected 0000 4", req_ready_o,
               outstanding_o);
    end
    tick();
    rsp_drive(1'b0);
    void'(mem_q.pop_front());
    exp_push(1, data_of(48'h2020));
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 4'b0010 || outstanding_o !== 3'd3) begin
      errors++;
      $display("FAIL stall_resume: got rdy=%b out=%0d, expected 0010 3", req_ready_o,
               outstanding_o);
    end
    tick();
    set_req(1, 1'b0, 1'b0, 48'h0);
    drain(4);
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd0) begin
      errors++;
      $display("FAIL stall_drained: got %0d, expected 0", outstanding_o);
    end
    tick();
  endtask

  task automatic test_back_pressure();
    set_req(3, 1'b1, 1'b0, 48'h4000);
    exp_push(3, data_of(48'h4000));
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 4'b1000) begin
      errors++;
      $display("FAIL bp_issue: got rdy=%b, expected 1000", req_ready_o);
    end
    tick();
    set_req(3, 1'b0, 1'b0, 48'h0);
    rsp_ready_i = 4'b0111;
    rsp_drive(1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      checks++;
      if (mem_rsp_ready_o !== 1'b0 || rsp_valid_o !== 4'b1000 ||
          rsp_data_o !== data_of(48'h4000) || outstanding_o !== 3'd1) begin
        errors++;
        $display("FAIL bp_hold%0d: got mrr=%b rv=%b data=%h out=%0d, expected 0 1000 %h 1", c,
                 mem_rsp_ready_o, rsp_valid_o, rsp_data_o, outstanding_o, data_of(48'h4000));
      end
      tick();
    end
    rsp_ready_i = '1;
    @(negedge clk_i);
    checks++;
    if (mem_rsp_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got mrr=%b, expected 1", mem_rsp_ready_o);
    end
    tick();
    rsp_drive(1'b0);
    void'(mem_q.pop_front());
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd0) begin
      errors++;
      $display("FAIL bp_popped: got %0d, expected 0", outstanding_o);
    end
    tick();
  endtask

  task automatic test_writes();
    for (int k = 0; k < 8; k++) begin
      logic [47:0] a;
      a = 48'(32'h6000 + 8 * k);
      set_req(2, 1'b1, 1'b1, a);
      if (k == 3) begin
        mem_req_ready_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (mem_req_valid_o !== 1'b1 || req_ready_o !== 4'b0) begin
          errors++;
          $display("FAIL wr_backpressure: got mv=%b rdy=%b, expected 1 0000", mem_req_valid_o,
                   req_ready_o);
        end
        tick();
        mem_req_ready_i = 1'b1;
      end
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 4'b0100 || mem_write_o !== 1'b1 || mem_addr_o !== a ||
          mem_wdata_o !== wdata_of(2, a) || mem_strb_o !== strb_of(2) ||
          outstanding_o !== 3'd0 || rsp_valid_o !== 4'b0) begin
        errors++;
        $display("FAIL wr_issue%0d: got rdy=%b wr=%b addr=%h wd=%h st=%h out=%0d rv=%b", k,
                 req_ready_o, mem_write_o, mem_addr_o, mem_wdata_o, mem_strb_o, outstanding_o,
                 rsp_valid_o);
      end
      tick();
    end
    set_req(2, 1'b0, 1'b0, 48'h0);
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd0) begin
      errors++;
      $display("FAIL wr_outstanding: got %0d, expected 0", outstanding_o);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    // Pointer is 3 after the port 2 writes; ports 0,1,2 are granted in that order.
    for (int p = 0; p < 3; p++) set_req(p, 1'b1, 1'b0, 48'(32'h7000 + 8 * p));
    for (int c = 0; c < 3; c++) begin
      exp_push(c, data_of(48'(32'h7000 + 8 * c)));
      @(negedge clk_i);
      checks++;
      if (req_ready_o !== 4'(1 << c)) begin
        errors++;
        $display("FAIL rst_fill%0d: got rdy=%b, expected %b", c, req_ready_o, 4'(1 << c));
      end
      tick();
      set_req(c, 1'b0, 1'b0, 48'h0);
    end
    rst_ni = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({outstanding_o, mem_rsp_ready_o, req_ready_o, rsp_valid_o, mem_req_valid_o} !==
        {3'd0, 1'b1, 4'b0, 4'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid: got out=%0d mrr=%b rdy=%b rv=%b mv=%b, expected 0 1 0 0 0",
               outstanding_o, mem_rsp_ready_o, req_ready_o, rsp_valid_o, mem_req_valid_o);
    end
    exp_q.delete();
    mem_q.delete();
    tick();
    rst_ni = 1'b1;
    set_req(0, 1'b1, 1'b0, 48'h7100);
    set_req(3, 1'b1, 1'b0, 48'h7200);
    exp_push(0, data_of(48'h7100));
    @(negedge clk_i);
    checks++;
    if (req_ready_o !== 4'b0001) begin
      errors++;
      $display("FAIL rst_pointer: got rdy=%b, expected 0001", req_ready_o);
    end
    tick();
    set_req(0, 1'b0, 1'b0, 48'h0);
    exp_push(3, data_of(48'h7200));
    tick();
    set_req(3, 1'b0, 1'b0, 48'h0);
    drain(2);
    @(negedge clk_i);
    checks++;
    if (outstanding_o !== 3'd0) begin
      errors++;
      $display("FAIL rst_after: got %0d, expected 0", outstanding_o);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_read();
    test_fairness();
    test_full_stall();
    test_back_pressure();
    test_writes();
    test_reset_mid();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending responses, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
